game_sequencer: RTL and testbench

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/tetris_pkg.sv | 14 +
 rtl/piece_gen.sv | 10 +
 rtl/game_sequencer.sv | 124 ++++++++++++
 tb/tb_game_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// tetris_pkg: shared piece/state types, board size and line-clear score table.
package tetris_pkg;
   typedef enum logic [2:0] {I = 3'd0, O, T, S, Z, J, L = 3'd6} piece_t;
   typedef enum logic [2:0] {IDLE, SPAWN, SPAWN_CHK, PLAY, MOVE_CHK, LOCK, CLEAR, GAMEOVER} seq_state_t;
   localparam int BOARD_W = 10;
   localparam int BOARD_H = 20;
   localparam logic [10:0] SCORE_1 = 11'd40;
   localparam logic [10:0] SCORE_2 = 11'd100;
   localparam logic [10:0] SCORE_3 = 11'd300;
   localparam logic [10:0] SCORE_4 = 11'd1200;
   function automatic logic [10:0] line_points(input logic [2:0] n);
      return n == 3'd1 ? SCORE_1 : n == 3'd2 ? SCORE_2 : n == 3'd3 ? SCORE_3 : n == 3'd4 ? SCORE_4 : 11'd0;
   endfunction
endpackage

// File: rtl/piece_gen.sv
// piece_gen: free-running mod-7 counter used as the next-piece source.
module piece_gen (
   input  logic       clk,
   input  logic       resetn,
   output logic [2:0] piece
);
   always_ff @(posedge clk)
      if (!resetn) piece <= 3'd0;
      else piece <= piece == 3'd6 ? 3'd0 : piece + 3'd1;
endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: falling-piece game FSM driving collision-check, lock and line-clear handshakes.
module game_sequencer
   import tetris_pkg::*;
#(
   parameter int SCORE_W   = 20,
   parameter int SPAWN_COL = 3
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                tick,
   input  logic                start,
   input  logic                cw,
   input  logic                ccw,
   input  logic                left,
   input  logic                right,
   output logic                chk_req,
   input  logic                chk_ack,
   output logic [4:0]          chk_row,
   output logic signed [4:0]   chk_col,
   output logic [1:0]          chk_rot,
   output logic [2:0]          chk_type,
   input  logic                chk_hit,
   output logic                lock_req,
   input  logic                lock_done,
   output logic                clr_req,
   input  logic                clr_done,
   input  logic [2:0]          clr_lines,
   output logic [4:0]          cur_row,
   output logic signed [4:0]   cur_col,
   output logic [1:0]          cur_rot,
   output logic [2:0]          cur_type,
   output logic [SCORE_W-1:0]  score,
   output logic                game_over,
   output logic                playing
);
   seq_state_t state, state_n;
   logic [2:0] gen;
   logic tick_prop, cmd, chk_done;
   logic [4:0] p_row;
   logic signed [4:0] p_col;
   logic [1:0] p_rot;
   logic [SCORE_W:0] sum;

   piece_gen u_gen (.clk(clk), .resetn(resetn), .piece(gen));

   assign cmd       = tick | cw | ccw | left | right;
   assign chk_done  = chk_req & chk_ack;
   assign lock_req  = state == LOCK;
   assign clr_req   = state == CLEAR;
   assign game_over = state == GAMEOVER;
   assign playing   = state != IDLE && state != GAMEOVER;
   assign sum       = {1'b0, score} + (SCORE_W + 1)'(line_points(clr_lines));

   always_comb begin
      p_row = tick ? cur_row + 5'd1 : cur_row;
      p_rot = tick ? cur_rot : cw ? cur_rot + 2'd1 : ccw ? cur_rot - 2'd1 : cur_rot;
      p_col = (tick | cw | ccw) ? cur_col : left ? cur_col - 5'sd1 : right ? cur_col + 5'sd1 : cur_col;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE, GAMEOVER: state_n = start ? SPAWN : state;
         SPAWN:          state_n = SPAWN_CHK;
         SPAWN_CHK:      state_n = chk_done ? (chk_hit ? GAMEOVER : PLAY) : state;
         PLAY:           state_n = cmd ? MOVE_CHK : state;
         MOVE_CHK:       state_n = chk_done ? (chk_hit && tick_prop ? LOCK : PLAY) : state;
         LOCK:           state_n = lock_done ? CLEAR : state;
         CLEAR:          state_n = clr_done ? SPAWN : state;
         default:        state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state     <= IDLE;
         score     <= '0;
         cur_row   <= '0;
         cur_col   <= '0;
         cur_rot   <= '0;
         cur_type  <= '0;
         chk_req   <= 1'b0;
         chk_row   <= '0;
         chk_col   <= '0;
         chk_rot   <= '0;
         chk_type  <= '0;
         tick_prop <= 1'b0;
      end else begin
         state <= state_n;
         if ((state == IDLE || state == GAMEOVER) && start) score <= '0;
         if (state == SPAWN) begin
            cur_type  <= gen;
            cur_row   <= '0;
            cur_col   <= 5'(SPAWN_COL);
            cur_rot   <= '0;
            chk_type  <= gen;
            chk_row   <= '0;
            chk_col   <= 5'(SPAWN_COL);
            chk_rot   <= '0;
            tick_prop <= 1'b0;
         end
         if (state == PLAY && cmd) begin
            chk_row   <= p_row;
            chk_col   <= p_col;
            chk_rot   <= p_rot;
            chk_type  <= cur_type;
            tick_prop <= tick;
         end
         // request rises one cycle into the check and drops the cycle after the ack
         if (state == SPAWN_CHK || state == MOVE_CHK) begin
            if (!chk_req) chk_req <= 1'b1;
            else if (chk_ack) begin
               chk_req <= 1'b0;
               if (state == MOVE_CHK && !chk_hit) begin
                  cur_row <= chk_row;
                  cur_col <= chk_col;
                  cur_rot <= chk_rot;
               end
            end
         end
         if (state == CLEAR && clr_done) score <= sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
      end
   end
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed scoreboard bench for game_sequencer (11-bit score to reach saturation).
module tb_game_sequencer;
   localparam int SW = 11;
   localparam int SMAX = (1 << SW) - 1;
   logic clk = 1'b0, resetn = 1'b0;
   logic tick = 0, start = 0, cw = 0, ccw = 0, left = 0, right = 0;
   logic chk_req, chk_ack = 0, chk_hit = 0, lock_req, lock_done = 0, clr_req, clr_done = 0;
   logic [2:0] clr_lines = 0;
   logic [4:0] chk_row, cur_row;
   logic signed [4:0] chk_col, cur_col;
   logic [1:0] chk_rot, cur_rot;
   logic [2:0] chk_type, cur_type;
   logic [SW-1:0] score;
   logic game_over, playing;
   typedef struct {logic [4:0] row; logic [4:0] col; logic [1:0] rot; logic [2:0] typ;} exp_t;
   exp_t exp_q[$];
   int sc_q[$];
   int tests = 0, fails = 0, m_gen = 0, m_type = 0, m_score = 0;

   game_sequencer #(.SCORE_W(SW), .SPAWN_COL(3)) dut (
      .clk(clk), .resetn(resetn), .tick(tick), .start(start), .cw(cw), .ccw(ccw),
      .left(left), .right(right), .chk_req(chk_req), .chk_ack(chk_ack), .chk_row(chk_row),
      .chk_col(chk_col), .chk_rot(chk_rot), .chk_type(chk_type), .chk_hit(chk_hit),
      .lock_req(lock_req), .lock_done(lock_done), .clr_req(clr_req), .clr_done(clr_done),
      .clr_lines(clr_lines), .cur_row(cur_row), .cur_col(cur_col), .cur_rot(cur_rot),
      .cur_type(cur_type), .score(score), .game_over(game_over), .playing(playing));

   always #10 clk = ~clk;
   always @(posedge clk) m_gen <= !resetn ? 0 : (m_gen + 1) % 7;

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic push(input int r, input int c, input int rot, input int t);
      exp_t e;
      e.row = 5'(r); e.col = 5'(c); e.rot = 2'(rot); e.typ = 3'(t);
      exp_q.push_back(e);
   endtask

   task automatic wait_chk;
      exp_t e;
      int n = 0;
      while (chk_req !== 1'b1 && n < 20) begin cyc; n++; end
      chk("chk_req_rise", chk_req, 1);
      if (exp_q.size() == 0) chk("chk_queue_empty", 0, 1);
      else begin
         e = exp_q.pop_front();
         chk("chk_row", chk_row, e.row);
         chk("chk_col", 5'(chk_col), e.col);
         chk("chk_rot", chk_rot, e.rot);
         chk("chk_type", chk_type, e.typ);
      end
   endtask

   task automatic ack(input logic hit);
      chk_ack = 1; chk_hit = hit;
      cyc;
      chk_ack = 0; chk_hit = 0;
      chk("chk_req_drop", chk_req, 0);
   endtask

   task automatic command(input logic t, input logic c, input logic cc, input logic l, input logic r);
      tick = t; cw = c; ccw = cc; left = l; right = r;
      cyc;
      tick = 0; cw = 0; ccw = 0; left = 0; right = 0;
   endtask

   task automatic do_spawn(input logic hit);
      cyc;
      m_type = (m_gen + 6) % 7;
      push(0, 3, 0, m_type);
      wait_chk;
      cyc; cyc;
      chk("chk_req_hold", chk_req, 1);
      chk("chk_row_hold", chk_row, 0);
      ack(hit);
      if (!hit) begin
         chk("spawn_row", cur_row, 0);
         chk("spawn_col", 5'(cur_col), 3);
         chk("spawn_rot", cur_rot, 0);
         chk("spawn_type", cur_type, m_type);
         chk("spawn_playing", playing, 1);
      end
   endtask

   task automatic lock_clear(input logic [2:0] lines);
      chk("lock_req", lock_req, 1);
      chk("clr_req_idle", clr_req, 0);
      cyc; cyc;
      chk("lock_req_hold", lock_req, 1);
      lock_done = 1;
      cyc;
      lock_done = 0;
      chk("lock_req_drop", lock_req, 0);
      chk("clr_req", clr_req, 1);
      m_score = m_score + int'(lines == 1 ? 40 : lines == 2 ? 100 : lines == 3 ? 300 : lines == 4 ? 1200 : 0);
      if (m_score > SMAX) m_score = SMAX;
      sc_q.push_back(m_score);
      clr_lines = lines; clr_done = 1;
      cyc;
      clr_done = 0; clr_lines = 0;
      chk("clr_req_drop", clr_req, 0);
      chk("score", score, sc_q.pop_front());
   endtask

   task automatic piece_round(input logic [2:0] lines);
      push(1, 3, 0, m_type);
      command(1, 0, 0, 0, 0);
      wait_chk;
      ack(1);
      lock_clear(lines);
      do_spawn(0);
   endtask

   initial begin
      cyc; cyc; cyc;
      chk("rst_playing", playing, 0);
      chk("rst_score", score, 0);
      chk("rst_chk_req", chk_req, 0);
      chk("rst_game_over", game_over, 0);
      chk("rst_cur_col", 5'(cur_col), 0);
      resetn = 1;
      start = 1;
      cyc;
      start = 0;
      chk("start_playing", playing, 1);
      do_spawn(0);
      push(1, 3, 0, m_type);
      command(1, 1, 0, 1, 0);
      wait_chk;
      ack(0);
      chk("tick_row", cur_row, 1);
      chk("tick_rot", cur_rot, 0);
      chk("tick_col", 5'(cur_col), 3);
      push(1, 3, 3, m_type);
      command(0, 0, 1, 0, 0);
      right = 1; cyc; right = 0;
      wait_chk;
      ack(0);
      chk("ccw_rot", cur_rot, 3);
      cyc;
      chk("ignored_right_col", 5'(cur_col), 3);
      push(1, 2, 3, m_type);
      command(0, 0, 0, 1, 0);
      wait_chk;
      ack(1);
      chk("left_hit_col", 5'(cur_col), 3);
      chk("left_hit_playing", playing, 1);
      push(1, 3, 0, m_type);
      command(0, 1, 0, 0, 0);
      wait_chk;
      ack(0);
      chk("cw_rot", cur_rot, 0);
      push(1, 4, 0, m_type);
      command(0, 0, 0, 0, 1);
      wait_chk;
      ack(0);
      chk("right_col", 5'(cur_col), 4);
      chk_ack = 1; lock_done = 1; clr_done = 1;
      cyc;
      chk_ack = 0; lock_done = 0; clr_done = 0;
      chk("stray_chk_req", chk_req, 0);
      chk("stray_lock_req", lock_req, 0);
      chk("stray_row", cur_row, 1);
      push(2, 4, 0, m_type);
      command(1, 0, 0, 0, 0);
      wait_chk;
      ack(1);
      lock_clear(3'd4);
      do_spawn(0);
      piece_round(3'd7);
      piece_round(3'd1);
      piece_round(3'd4);
      chk("saturated", score, SMAX);
      push(1, 3, 0, m_type);
      command(1, 0, 0, 0, 0);
      wait_chk;
      ack(1);
      lock_clear(3'd2);
      do_spawn(1);
      chk("go_game_over", game_over, 1);
      chk("go_playing", playing, 0);
      command(1, 1, 0, 0, 0);
      chk_ack = 1;
      cyc; cyc;
      chk_ack = 0;
      chk("go_cmd_ignored_req", chk_req, 0);
      chk("go_held", game_over, 1);
      start = 1;
      cyc;
      start = 0;
      chk("restart_score", score, 0);
      chk("restart_game_over", game_over, 0);
      chk("restart_playing", playing, 1);
      m_score = 0;
      do_spawn(0);
      push(1, 3, 0, m_type);
      command(1, 0, 0, 0, 0);
      wait_chk;
      resetn = 0;
      cyc;
      chk("midrst_chk_req", chk_req, 0);
      chk("midrst_playing", playing, 0);
      chk("midrst_score", score, 0);
      resetn = 1;
      chk_ack = 1; lock_done = 1; clr_done = 1;
      cyc;
      chk_ack = 0; lock_done = 0; clr_done = 0;
      cyc;
      chk("late_ack_chk_req", chk_req, 0);
      chk("late_ack_playing", playing, 0);
      chk("late_ack_lock", lock_req, 0);
      chk("late_ack_row", cur_row, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
